// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: oversampled framing with parity/timeout checks, E0/F0
// prefix folding into one code strobe, and per-key press state with LED hold.
module ps2_key_decoder #(
    parameter int                      CLK_DIV       = 250,
    parameter int                      TIMEOUT_TICKS = 4000,
    parameter int                      NUM_KEYS      = 2,
    parameter logic [NUM_KEYS*9-1:0]   KEY_CODES     = {9'h16B, 9'h174},
    parameter int                      HOLD_CYCLES   = 10_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic                code_valid,
    output logic [7:0]          code,
    output logic                code_ext,
    output logic                code_break,
    output logic                frame_err,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_led
);

    localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and sample tick
    // ------------------------------------------------------------------
    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             ps2_clk_s;
    logic             ps2_data_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic             prev_clk;
    logic             fall;

    assign ps2_clk_s  = clk_sync[1];
    assign ps2_data_s = data_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            prev_clk <= 1'b1;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                prev_clk <= ps2_clk_s;
            end
        end
    end

    // Edges only count when the divided tick samples the line.
    assign fall = tick & prev_clk & ~ps2_clk_s;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t           state, state_n;
    logic [10:0]      shreg, shreg_n;
    logic [3:0]       bitcnt, bitcnt_n;
    logic [TMO_W-1:0] tmo, tmo_n;
    logic             ext_flag, ext_n;
    logic             brk_flag, brk_n;
    logic             valid_n, err_n;
    logic [7:0]       code_n;
    logic             code_ext_n, code_brk_n;
    logic             frame_ok;
    logic [7:0]       frame_byte;

    assign frame_byte = shreg[8:1];
    // shreg holds {stop, parity, data[7:0], start} once eleven bits are in.
    assign frame_ok   = ~shreg[0] & shreg[10] & (^shreg[9:1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            tmo        <= '0;
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            code       <= '0;
            code_ext   <= 1'b0;
            code_break <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bitcnt     <= bitcnt_n;
            tmo        <= tmo_n;
            ext_flag   <= ext_n;
            brk_flag   <= brk_n;
            code_valid <= valid_n;
            frame_err  <= err_n;
            code       <= code_n;
            code_ext   <= code_ext_n;
            code_break <= code_brk_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bitcnt_n   = bitcnt;
        tmo_n      = tmo;
        ext_n      = ext_flag;
        brk_n      = brk_flag;
        valid_n    = 1'b0;
        err_n      = 1'b0;
        code_n     = code;
        code_ext_n = code_ext;
        code_brk_n = code_break;

        case (state)
            IDLE: begin
                // A fall with data high is line noise, not a start bit.
                if (fall && !ps2_data_s) begin
                    state_n  = RECV;
                    shreg_n  = {ps2_data_s, shreg[10:1]};
                    bitcnt_n = 4'd1;
                    tmo_n    = '0;
                end
            end

            RECV: begin
                if (fall) begin
                    shreg_n  = {ps2_data_s, shreg[10:1]};
                    bitcnt_n = bitcnt + 4'd1;
                    tmo_n    = '0;
                    if (bitcnt == 4'd10) begin
                        state_n = CHECK;
                    end
                end else if (tick) begin
                    if (tmo == TMO_LAST) begin
                        state_n = IDLE;
                        err_n   = 1'b1;
                        ext_n   = 1'b0;
                        brk_n   = 1'b0;
                        tmo_n   = '0;
                    end else begin
                        tmo_n = tmo + TMO_W'(1);
                    end
                end
            end

            CHECK: begin
                state_n = IDLE;
                if (!frame_ok) begin
                    err_n = 1'b1;
                    ext_n = 1'b0;
                    brk_n = 1'b0;
                end else if (frame_byte == 8'hE0) begin
                    ext_n = 1'b1;
                end else if (frame_byte == 8'hF0) begin
                    brk_n = 1'b1;
                end else begin
                    valid_n    = 1'b1;
                    code_n     = frame_byte;
                    code_ext_n = ext_flag;
                    code_brk_n = brk_flag;
                    ext_n      = 1'b0;
                    brk_n      = 1'b0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Watched key channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [HOLD_W-1:0] hold_cnt;
        logic              pressed_r;
        logic              led_r;
        logic              hit;

        assign hit            = code_valid && ({code_ext, code} == KEY_CODES[9*i +: 9]);
        assign key_pressed[i] = pressed_r;
        assign key_led[i]     = led_r;

        always_ff @(posedge clk) begin
            if (rst) begin
                pressed_r <= 1'b0;
                hold_cnt  <= '0;
                led_r     <= 1'b0;
            end else begin
                if (hit) begin
                    pressed_r <= ~code_break;
                end
                // A break leaves the hold running; only makes reload it.
                if (hit && !code_break) begin
                    hold_cnt <= HOLD_LOAD;
                    led_r    <= 1'b1;
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                    led_r    <= (hold_cnt != HOLD_W'(1));
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of complete key sequences plus
// hand-written LED hold, parity, timeout and mid-frame reset sequences.
module tb_ps2_key_decoder;

    localparam int NK = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          code_valid;
    logic [7:0]    code;
    logic          code_ext;
    logic          code_break;
    logic          frame_err;
    logic [NK-1:0] key_pressed;
    logic [NK-1:0] key_led;

    ps2_key_decoder #(
        .CLK_DIV       (4),
        .TIMEOUT_TICKS (50),
        .NUM_KEYS      (NK),
        .KEY_CODES     ({9'h01C, 9'h16B, 9'h174}),
        .HOLD_CYCLES   (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .code_valid  (code_valid),
        .code        (code),
        .code_ext    (code_ext),
        .code_break  (code_break),
        .frame_err   (frame_err),
        .key_pressed (key_pressed),
        .key_led     (key_led)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // scoreboard: {err, ext, brk, code}; 11'h400 is a frame error
    logic [10:0] exp_q[$];
    int          last_valid_cyc = 0;
    int          led_fall_cyc[NK];
    int          led_falls[NK];
    logic [NK-1:0] led_prev = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic check_event(input string name, input logic [10:0] got);
        logic [10:0] want;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 11'h7FF;
        check(name, {21'b0, got}, {21'b0, want});
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (code_valid) begin
                last_valid_cyc = cyc;
                check_event("code_event", {1'b0, code_ext, code_break, code});
            end
            if (frame_err) begin
                check_event("err_event", 11'h400);
            end
        end
        for (int i = 0; i < NK; i++) begin
            if (led_prev[i] && !key_led[i]) begin
                led_fall_cyc[i] = cyc;
                led_falls[i]++;
            end
        end
        led_prev = key_led;
    end

    // driver tasks
    task automatic send_bit(input logic b, input int half);
        ps2_data = b;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int half, input logic bad_par);
        send_bit(1'b0, half);
        for (int i = 0; i < 8; i++) send_bit(d[i], half);
        send_bit(~(^d) ^ bad_par, half);
        send_bit(1'b1, half);
        repeat (half * 2) @(negedge clk);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    typedef struct {
        logic [23:0] bytes;
        int          n;
        logic [10:0] exp;
        logic [NK-1:0] pressed;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int s;
        int n0;

        vecs[0] = '{24'h0074E0, 2, {3'b010, 8'h74}, 3'b001};
        vecs[1] = '{24'h74F0E0, 3, {3'b011, 8'h74}, 3'b000};
        vecs[2] = '{24'h00001C, 1, {3'b000, 8'h1C}, 3'b100};
        vecs[3] = '{24'h00006B, 1, {3'b000, 8'h6B}, 3'b100};
        vecs[4] = '{24'h006BE0, 2, {3'b010, 8'h6B}, 3'b110};
        vecs[5] = '{24'h001CF0, 2, {3'b001, 8'h1C}, 3'b010};
        vecs[6] = '{24'h6BF0E0, 3, {3'b011, 8'h6B}, 3'b000};

        repeat (5) @(negedge clk);
        check("rst_code_valid", code_valid, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_code", code, 0);
        check("rst_key_pressed", key_pressed, 0);
        check("rst_key_led", key_led, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            exp_q.push_back(vecs[v].exp);
            for (int k = 0; k < vecs[v].n; k++) send_frame(vecs[v].bytes[8*k +: 8], 16, 1'b0);
            wait_drain("vec_drain");
            check("vec_pressed", key_pressed, vecs[v].pressed);
        end

        // LED hold after a make
        exp_q.push_back({3'b010, 8'h74});
        send_frame(8'hE0, 16, 1'b0);
        send_frame(8'h74, 16, 1'b0);
        wait_drain("led_drain");
        s = last_valid_cyc;
        repeat (130) @(negedge clk);
        check("led0_fall_cyc", led_fall_cyc[0], s + 101);
        check("led_pressed", key_pressed, 3'b001);

        // F0 then a bad-parity frame: prefix is dropped with the error
        send_frame(8'hF0, 16, 1'b0);
        exp_q.push_back(11'h400);
        send_frame(8'h1C, 16, 1'b1);
        wait_drain("par_err_drain");
        exp_q.push_back({3'b000, 8'h1C});
        send_frame(8'h1C, 16, 1'b0);
        wait_drain("par_ok_drain");
        check("par_pressed", key_pressed, 3'b101);

        // Back-to-back fast makes reload the hold without a dropout
        repeat (150) @(negedge clk);
        n0 = led_falls[2];
        exp_q.push_back({3'b000, 8'h1C});
        exp_q.push_back({3'b000, 8'h1C});
        send_frame(8'h1C, 4, 1'b0);
        send_frame(8'h1C, 4, 1'b0);
        wait_drain("retrig_drain");
        s = last_valid_cyc;
        repeat (130) @(negedge clk);
        check("led2_fall_count", led_falls[2] - n0, 1);
        check("led2_fall_cyc", led_fall_cyc[2], s + 101);

        // Stalled frame after E0: timeout error, prefix cleared
        send_frame(8'hE0, 16, 1'b0);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        exp_q.push_back(11'h400);
        repeat (150) @(negedge clk);
        check("tmo_not_early", exp_q.size(), 1);
        for (int i = 0; i < 120 && exp_q.size() != 0; i++) @(negedge clk);
        check("tmo_drain", exp_q.size(), 0);
        exp_q.push_back({3'b000, 8'h6B});
        send_frame(8'h6B, 16, 1'b0);
        wait_drain("tmo_next_drain");
        check("tmo_pressed", key_pressed, 3'b101);

        // Reset mid-frame with a pending F0
        send_frame(8'hF0, 16, 1'b0);
        send_bit(1'b0, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_code_valid", code_valid, 0);
        check("mrst_code", code, 0);
        check("mrst_pressed", key_pressed, 0);
        check("mrst_led", key_led, 0);
        repeat (20) @(negedge clk);
        exp_q.push_back({3'b010, 8'h6B});
        send_frame(8'hE0, 16, 1'b0);
        send_frame(8'h6B, 16, 1'b0);
        wait_drain("mrst_next_drain");
        check("mrst_next_pressed", key_pressed, 3'b010);

        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
